// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port valid/ready arbiter and sequencer in front of a
// single-port SRAM with a 1-cycle registered read.
// Port 0 = CPU load/store unit, port 1 = DMA/loader.
// One request is accepted per cycle. The SRAM command is registered (cycle t+1).
// Read data returns on the requesting port at cycle t+2, in issue order.
// Optional feature: define SRAM_ARB_PERF_EN to add the p0_grant_cnt and
// p1_grant_cnt outputs. Each is a saturating 16-bit handshake counter.
module sram_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p0_valid,
    input  logic         p0_write,
    input  logic [N-1:0] p0_addr,
    input  logic [N-1:0] p0_wdata,
    output logic         p0_ready,
    output logic         p0_rsp_valid,
    output logic [N-1:0] p0_rsp_data,
    input  logic         p1_valid,
    input  logic         p1_write,
    input  logic [N-1:0] p1_addr,
    input  logic [N-1:0] p1_wdata,
    output logic         p1_ready,
    output logic         p1_rsp_valid,
    output logic [N-1:0] p1_rsp_data,
    output logic         SRAM_readEnable,
    output logic         SRAM_writeEnable,
    output logic [N-1:0] SRAM_address,
    output logic [N-1:0] SRAM_data_in,
    input  logic [N-1:0] SRAM_data
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [15:0]  p0_grant_cnt,
    output logic [15:0]  p1_grant_cnt
`endif
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0] BURST_ONE = BW'(1);

    typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;

    typedef struct packed {
        logic         write;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
    } req_t;

    owner_t        state_q, state_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic          gnt0, gnt1;
    req_t          sel_req;

    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [N-1:0]  addr_q, addr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic          cmd_tag_q, cmd_tag_d;   // port that issued the command now on the SRAM
    logic          rsp_vld_q, rsp_vld_d;   // read data is on SRAM_data this cycle
    logic          rsp_tag_q, rsp_tag_d;   // port that read data belongs to

    // Arbitration: pick at most one port and track the owner and its burst length
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        if (p0_valid && p1_valid) begin
            if (burst_cnt_q < BURST_MAX) begin
                // Owner keeps the slot until its burst budget is used up
                gnt0        = (state_q == OWN0);
                gnt1        = (state_q == OWN1);
                burst_cnt_d = burst_cnt_q + BURST_ONE;
            end else begin
                gnt0        = (state_q == OWN1);
                gnt1        = (state_q == OWN0);
                state_d     = (state_q == OWN0) ? OWN1 : OWN0;
                burst_cnt_d = BURST_ONE;
            end
        end else if (p0_valid) begin
            gnt0 = 1'b1;
            if (state_q != OWN0) begin
                state_d     = OWN0;
                burst_cnt_d = BURST_ONE;
            end else if (burst_cnt_q < BURST_MAX) begin
                burst_cnt_d = burst_cnt_q + BURST_ONE;
            end
        end else if (p1_valid) begin
            gnt1 = 1'b1;
            if (state_q != OWN1) begin
                state_d     = OWN1;
                burst_cnt_d = BURST_ONE;
            end else if (burst_cnt_q < BURST_MAX) begin
                burst_cnt_d = burst_cnt_q + BURST_ONE;
            end
        end else begin
            burst_cnt_d = '0;
        end
        // Nothing is accepted while reset is asserted
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Command and response pipeline: latch the granted request and track read tags
    always_comb begin
        sel_req   = gnt1 ? {p1_write, p1_addr, p1_wdata} : {p0_write, p0_addr, p0_wdata};
        ren_d     = 1'b0;
        wen_d     = 1'b0;
        addr_d    = '0;
        wdata_d   = '0;
        cmd_tag_d = gnt1;
        if (gnt0 || gnt1) begin
            ren_d  = !sel_req.write;
            wen_d  = sel_req.write;
            addr_d = sel_req.addr;
            if (sel_req.write) wdata_d = sel_req.wdata;
        end
        rsp_vld_d = ren_q;
        rsp_tag_d = cmd_tag_q;
    end

    // State, command and response registers; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= OWN0;
            burst_cnt_q <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_tag_q   <= 1'b0;
            rsp_vld_q   <= 1'b0;
            rsp_tag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_tag_q   <= cmd_tag_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign p0_ready         = gnt0;
    assign p1_ready         = gnt1;
    assign SRAM_readEnable  = ren_q;
    assign SRAM_writeEnable = wen_q;
    assign SRAM_address     = addr_q;
    assign SRAM_data_in     = wdata_q;
    assign p0_rsp_valid     = rsp_vld_q && !rsp_tag_q && !rst;
    assign p1_rsp_valid     = rsp_vld_q && rsp_tag_q && !rst;
    assign p0_rsp_data      = p0_rsp_valid ? SRAM_data : '0;
    assign p1_rsp_data      = p1_rsp_valid ? SRAM_data : '0;

`ifdef SRAM_ARB_PERF_EN
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Saturating per-port handshake counters
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
        if (gnt1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
    end

    // Counter registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign p0_grant_cnt = cnt0_q;
    assign p1_grant_cnt = cnt1_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter. It contains a behavioural SRAM, a
// reference memory and a response scoreboard.
// Build with SRAM_ARB_PERF_EN defined to also exercise the grant counters.
module tb_sram_arbiter;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         p0_valid = 1'b0, p0_write = 1'b0;
    logic [N-1:0] p0_addr = '0, p0_wdata = '0;
    logic         p1_valid = 1'b0, p1_write = 1'b0;
    logic [N-1:0] p1_addr = '0, p1_wdata = '0;
    logic         p0_ready, p0_rsp_valid, p1_ready, p1_rsp_valid;
    logic [N-1:0] p0_rsp_data, p1_rsp_data;
    logic         SRAM_readEnable, SRAM_writeEnable;
    logic [N-1:0] SRAM_address, SRAM_data_in, SRAM_data;
`ifdef SRAM_ARB_PERF_EN
    logic [15:0]  p0_grant_cnt, p1_grant_cnt;
`endif

    always #5 clk = ~clk;

    sram_arbiter #(.N(N), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
        .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
        .SRAM_readEnable(SRAM_readEnable), .SRAM_writeEnable(SRAM_writeEnable),
        .SRAM_address(SRAM_address), .SRAM_data_in(SRAM_data_in), .SRAM_data(SRAM_data)
`ifdef SRAM_ARB_PERF_EN
        , .p0_grant_cnt(p0_grant_cnt), .p1_grant_cnt(p1_grant_cnt)
`endif
    );

    // Behavioural single-port SRAM with a registered read
    logic [N-1:0] mem [256];
    logic [N-1:0] sram_q = '0;
    always @(posedge clk) begin
        if (SRAM_writeEnable) mem[SRAM_address] <= SRAM_data_in;
        if (SRAM_readEnable)  sram_q <= mem[SRAM_address];
    end
    assign SRAM_data = sram_q;

    typedef struct {
        bit           wr;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
    } req_t;

    typedef struct {
        int           due;
        bit           port;
        logic [N-1:0] data;
    } exp_t;

    req_t         rq0[$], rq1[$];
    exp_t         sb[$];
    int           glog[$];
    logic [N-1:0] ref_mem [256];
    int           checks = 0, errors = 0;
    int           cyc = 0;
    bit           rst_prev = 1'b0;
    bit           acc0 = 1'b0, acc1 = 1'b0;
    bit           drv_en = 1'b0;
    int           rsp0_cnt = 0;
    logic [N-1:0] last_rsp0 = '0, last_rsp1 = '0;
    exp_t         e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_prev <= rst;
    end

    // Monitor: checks outputs mid-cycle, records accepts, and scores responses
    always @(negedge clk) begin
        acc0 = 1'b0;
        acc1 = 1'b0;
        chk("one_enable", 32'(SRAM_readEnable & SRAM_writeEnable), 32'(0));
        chk("one_ready", 32'(p0_ready & p1_ready), 32'(0));
        if (rst_prev)
            chk("sram_after_rst", 32'({SRAM_readEnable, SRAM_writeEnable, SRAM_address, SRAM_data_in}), 32'(0));
        else if (!SRAM_readEnable && !SRAM_writeEnable)
            chk("sram_idle", 32'({SRAM_address, SRAM_data_in}), 32'(0));
        if (rst) begin
            chk("rst_outputs", 32'({p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_data, p1_rsp_data}), 32'(0));
            sb.delete();
        end else begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("rsp_valid0", 32'(p0_rsp_valid), 32'(!e.port));
                chk("rsp_valid1", 32'(p1_rsp_valid), 32'(e.port));
                chk("rsp_data", 32'(e.port ? p1_rsp_data : p0_rsp_data), 32'(e.data));
                chk("rsp_other_zero", 32'(e.port ? p0_rsp_data : p1_rsp_data), 32'(0));
            end else begin
                chk("no_rsp", 32'({p0_rsp_valid, p1_rsp_valid, p0_rsp_data, p1_rsp_data}), 32'(0));
            end
            if (p0_rsp_valid) begin last_rsp0 = p0_rsp_data; rsp0_cnt++; end
            if (p1_rsp_valid) last_rsp1 = p1_rsp_data;
            if (p0_valid && p0_ready) begin
                acc0 = 1'b1;
                glog.push_back(0);
                if (p0_write) ref_mem[p0_addr] = p0_wdata;
                else begin e.due = cyc + 2; e.port = 1'b0; e.data = ref_mem[p0_addr]; sb.push_back(e); end
            end
            if (p1_valid && p1_ready) begin
                acc1 = 1'b1;
                glog.push_back(1);
                if (p1_write) ref_mem[p1_addr] = p1_wdata;
                else begin e.due = cyc + 2; e.port = 1'b1; e.data = ref_mem[p1_addr]; sb.push_back(e); end
            end
        end
    end

    task automatic push_req(input bit port, input bit wr, input logic [N-1:0] a, input logic [N-1:0] d);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d;
        if (port) rq1.push_back(r); else rq0.push_back(r);
    endtask

    // One clock: retire accepted requests, then present the queue heads
    task automatic cycle();
        @(posedge clk);
        #1;
        if (acc0 && rq0.size() > 0) void'(rq0.pop_front());
        if (acc1 && rq1.size() > 0) void'(rq1.pop_front());
        if (drv_en) begin
            p0_valid = rq0.size() > 0;
            if (p0_valid) begin p0_write = rq0[0].wr; p0_addr = rq0[0].addr; p0_wdata = rq0[0].wdata; end
            p1_valid = rq1.size() > 0;
            if (p1_valid) begin p1_write = rq1[0].wr; p1_addr = rq1[0].addr; p1_wdata = rq1[0].wdata; end
        end
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || sb.size() > 0) && n < maxc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", 32'(n >= maxc), 32'(0));
        cycle();
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     <= N'(i) ^ 8'h5A;
            ref_mem[i] = N'(i) ^ 8'h5A;
        end

        // Reset held 3 cycles with both ports requesting
        rst = 1'b1;
        p0_valid = 1'b1; p0_write = 1'b0; p0_addr = 8'h01;
        p1_valid = 1'b1; p1_write = 1'b1; p1_addr = 8'h02; p1_wdata = 8'hEE;
        repeat (3) cycle();
        rst = 1'b0;
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        drv_en = 1'b1;
        cycle();
        chk("no_accept_in_rst", 32'(glog.size()), 32'(0));

        // Back-to-back write then read of the same address on port 0
        push_req(0, 1, 8'h10, 8'hA5);
        push_req(0, 0, 8'h10, 8'h00);
        run_idle(50);
        chk("wr_rd_a5", 32'(last_rsp0), 32'(8'hA5));

        // Both ports streaming reads: bursts of 4 alternate ownership
        glog.delete();
        for (int i = 0; i < 8; i++) begin
            push_req(0, 0, 8'h40 + N'(i), 8'h00);
            push_req(1, 0, 8'h80 + N'(i), 8'h00);
        end
        run_idle(100);
        chk("burst_len", 32'(glog.size()), 32'(16));
        for (int i = 0; i < 16 && i < glog.size(); i++)
            chk("burst_gnt", 32'(glog[i]), 32'((i / 4) % 2));

        // Owner is P1: P1 write and P0 read of the same address offered together
        glog.delete();
        push_req(1, 1, 8'h20, 8'h3C);
        push_req(0, 0, 8'h20, 8'h00);
        run_idle(50);
        chk("order_len", 32'(glog.size()), 32'(2));
        if (glog.size() == 2) begin
            chk("order_first", 32'(glog[0]), 32'(1));
            chk("order_second", 32'(glog[1]), 32'(0));
        end
        chk("wr_rd_3c", 32'(last_rsp0), 32'(8'h3C));

        // Reset with a read in flight: the response must be dropped
        begin
            int r0;
            r0 = rsp0_cnt;
            glog.delete();
            push_req(0, 0, 8'h10, 8'h00);
            cycle();
            cycle();
            chk("inflight_accepted", 32'(glog.size()), 32'(1));
            rst = 1'b1;
            cycle();
            rst = 1'b0;
            repeat (4) cycle();
            chk("inflight_dropped", 32'(rsp0_cnt), 32'(r0));
        end

        // Random mixed traffic on a small address window
        for (int i = 0; i < 30; i++) begin
            push_req(0, 1'($urandom_range(0, 1)), 8'hC0 + N'($urandom_range(0, 7)), N'($urandom));
            push_req(1, 1'($urandom_range(0, 1)), 8'hC0 + N'($urandom_range(0, 7)), N'($urandom));
        end
        run_idle(500);

`ifdef SRAM_ARB_PERF_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("perf_rst0", 32'(p0_grant_cnt), 32'(0));
        chk("perf_rst1", 32'(p1_grant_cnt), 32'(0));
        for (int i = 0; i < 5; i++) push_req(0, 0, 8'h30 + N'(i), 8'h00);
        for (int i = 0; i < 3; i++) push_req(1, 1, 8'h50 + N'(i), N'(i));
        run_idle(100);
        chk("perf_cnt0", 32'(p0_grant_cnt), 32'(5));
        chk("perf_cnt1", 32'(p1_grant_cnt), 32'(3));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
